csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_pkg.sv | 51 +++++
 rtl/csr_timer.sv | 54 +++++
 rtl/csr_unit.sv | 202 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR addresses, field positions and exception codes for csr_unit.
// Field constants are LSB positions and widths so that callers can slice with +:.
package csr_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00c;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam int CRMD_PLV_LSB       = 0;
  localparam int CRMD_PLV_W         = 2;
  localparam int CRMD_IE            = 2;
  localparam int PRMD_PPLV_LSB      = 0;
  localparam int PRMD_PPLV_W        = 2;
  localparam int PRMD_PIE           = 2;
  localparam int ECFG_LIE_W         = 13;
  localparam int ESTAT_IS_SW_W      = 2;
  localparam int ESTAT_ECODE_LSB    = 16;
  localparam int ESTAT_ECODE_W      = 6;
  localparam int ESTAT_ESUBCODE_LSB = 22;
  localparam int ESTAT_ESUBCODE_W   = 9;
  localparam int EENTRY_VA_LSB      = 6;
  localparam int EENTRY_VA_W        = 26;
  localparam int TCFG_EN            = 0;
  localparam int TCFG_PERIODIC      = 1;
  localparam int TCFG_INITV_LSB     = 2;
  localparam int TICLR_CLR          = 0;

  // LIE[10] has no interrupt source behind it and is kept at zero.
  localparam logic [12:0] ECFG_LIE_MASK = 13'h1bff;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0b;

  function automatic logic [31:0] wmerge(input logic [31:0] old_val,
                                         input logic [31:0] mask,
                                         input logic [31:0] new_val);
    return (mask & new_val) | (~mask & old_val);
  endfunction

endpackage

// File: rtl/csr_timer.sv
// TCFG/TVAL down-counter and the timer interrupt flag (ESTAT.IS[11]).
// Only instantiated by csr_unit when CSR_TIMER_EN is defined.
module csr_timer import csr_pkg::*; #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               tcfg_we,
  input  logic               ticlr_we,
  input  logic [TIMER_W-1:0] wmask,
  input  logic [TIMER_W-1:0] wvalue,
  output logic [TIMER_W-1:0] tcfg,
  output logic [TIMER_W-1:0] tval,
  output logic               timer_int
);

  logic [TIMER_W-1:0] tcfg_new;
  logic [TIMER_W-1:0] reload_new;
  logic [TIMER_W-1:0] reload_cur;
  logic               expire;

  assign tcfg_new   = (wmask & wvalue) | (~wmask & tcfg);
  assign reload_new = {tcfg_new[TIMER_W-1:TCFG_INITV_LSB], 2'b00};
  assign reload_cur = {tcfg[TIMER_W-1:TCFG_INITV_LSB], 2'b00};
  // A TCFG write replaces the count, so it suppresses a 1->0 transition that edge.
  assign expire     = !tcfg_we && tcfg[TCFG_EN] && (tval == TIMER_W'(1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg      <= '0;
      tval      <= '0;
      timer_int <= 1'b0;
    end else begin
      if (tcfg_we) begin
        tcfg <= tcfg_new;
        tval <= reload_new;
      end else if (tcfg[TCFG_EN]) begin
        if (tval != '0) begin
          tval <= tval - TIMER_W'(1);
        end else if (tcfg[TCFG_PERIODIC]) begin
          tval <= reload_cur;
        end
      end

      // Setting wins over a same-cycle clear so an expiry is never lost.
      if (expire) begin
        timer_int <= 1'b1;
      end else if (ticlr_we) begin
        timer_int <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Control/status register file: CRMD..EENTRY, SAVEn, TID and the exception/ERTN update path.
// Define CSR_TIMER_EN to build in the TCFG/TVAL/TICLR timer; otherwise those read 0.
module csr_unit import csr_pkg::*; #(
  parameter int          SAVE_NUM   = 4,
  parameter int          HW_INT_NUM = 8,
  parameter int          TIMER_W    = 32,
  parameter logic [31:0] TID_RESET  = 32'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  csr_re,
  input  logic [13:0]           csr_num,
  output logic [31:0]           csr_rvalue,
  input  logic                  csr_we,
  input  logic [31:0]           csr_wmask,
  input  logic [31:0]           csr_wvalue,
  input  logic                  wb_ex,
  input  logic [5:0]            wb_ecode,
  input  logic [8:0]            wb_esubcode,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_vaddr,
  input  logic                  ertn_flush,
  input  logic [HW_INT_NUM-1:0] hw_int_in,
  input  logic                  ipi_int_in,
  output logic [31:0]           ex_entry,
  output logic [31:0]           ertn_entry,
  output logic                  has_int
);

  logic [1:0]  crmd_plv;
  logic        crmd_ie;
  logic [1:0]  prmd_pplv;
  logic        prmd_pie;
  logic [12:0] ecfg_lie;
  logic [1:0]  estat_is_sw;
  logic [7:0]  estat_is_hw;
  logic        estat_is_ipi;
  logic [5:0]  estat_ecode;
  logic [8:0]  estat_esubcode;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry_va;
  logic [31:0] save_r [SAVE_NUM];
  logic [31:0] tid;

  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;
  logic               timer_int;

  logic [12:0] estat_is;
  logic [3:0]  save_idx;
  logic        save_hit;
  logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry, wr_save, wr_tid;

  assign save_idx  = csr_num[3:0];
  assign save_hit  = (csr_num[13:4] == CSR_SAVE0[13:4]);
  assign wr_crmd   = csr_we && (csr_num == CSR_CRMD);
  assign wr_prmd   = csr_we && (csr_num == CSR_PRMD);
  assign wr_ecfg   = csr_we && (csr_num == CSR_ECFG);
  assign wr_estat  = csr_we && (csr_num == CSR_ESTAT);
  assign wr_era    = csr_we && (csr_num == CSR_ERA);
  assign wr_badv   = csr_we && (csr_num == CSR_BADV);
  assign wr_eentry = csr_we && (csr_num == CSR_EENTRY);
  assign wr_tid    = csr_we && (csr_num == CSR_TID);
  assign wr_save   = csr_we && save_hit;

  assign estat_is   = {estat_is_ipi, timer_int, 1'b0, estat_is_hw, estat_is_sw};
  assign has_int    = crmd_ie & (|(estat_is & ecfg_lie));
  assign ex_entry   = {eentry_va, 6'b0};
  assign ertn_entry = era;

`ifdef CSR_TIMER_EN
  logic wr_tcfg, wr_ticlr;
  assign wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
  assign wr_ticlr = csr_we && (csr_num == CSR_TICLR)
                    && csr_wmask[TICLR_CLR] && csr_wvalue[TICLR_CLR];

  csr_timer #(
    .TIMER_W (TIMER_W)
  ) u_timer (
    .clk       (clk),
    .resetn    (resetn),
    .tcfg_we   (wr_tcfg),
    .ticlr_we  (wr_ticlr),
    .wmask     (csr_wmask[TIMER_W-1:0]),
    .wvalue    (csr_wvalue[TIMER_W-1:0]),
    .tcfg      (tcfg),
    .tval      (tval),
    .timer_int (timer_int)
  );
`else
  assign tcfg      = '0;
  assign tval      = '0;
  assign timer_int = 1'b0;
`endif

  always_comb begin
    csr_rvalue = '0;
    if (csr_re) begin
      case (csr_num)
        CSR_CRMD:   csr_rvalue = {28'b0, 1'b1, crmd_ie, crmd_plv};
        CSR_PRMD:   csr_rvalue = {29'b0, prmd_pie, prmd_pplv};
        CSR_ECFG:   csr_rvalue = {19'b0, ecfg_lie};
        CSR_ESTAT:  csr_rvalue = {1'b0, estat_esubcode, estat_ecode, 3'b0, estat_is};
        CSR_ERA:    csr_rvalue = era;
        CSR_BADV:   csr_rvalue = badv;
        CSR_EENTRY: csr_rvalue = {eentry_va, 6'b0};
        CSR_TID:    csr_rvalue = tid;
        CSR_TCFG:   csr_rvalue = 32'(tcfg);
        CSR_TVAL:   csr_rvalue = 32'(tval);
        default:    csr_rvalue = '0;
      endcase
      if (save_hit) begin
        for (int i = 0; i < SAVE_NUM; i++) begin
          if (save_idx == i[3:0]) csr_rvalue = save_r[i];
        end
      end
    end
  end

  // Per-field priority: exception commit, then ERTN, then software write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      crmd_plv       <= '0;
      crmd_ie        <= 1'b0;
      prmd_pplv      <= '0;
      prmd_pie       <= 1'b0;
      ecfg_lie       <= '0;
      estat_is_sw    <= '0;
      estat_is_hw    <= '0;
      estat_is_ipi   <= 1'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
      era            <= '0;
      badv           <= '0;
      eentry_va      <= '0;
      tid            <= TID_RESET;
      for (int i = 0; i < SAVE_NUM; i++) save_r[i] <= '0;
    end else begin
      estat_is_hw  <= 8'(hw_int_in);
      estat_is_ipi <= ipi_int_in;

      if (wb_ex) begin
        crmd_plv <= '0;
        crmd_ie  <= 1'b0;
      end else if (ertn_flush) begin
        crmd_plv <= prmd_pplv;
        crmd_ie  <= prmd_pie;
      end else if (wr_crmd) begin
        crmd_plv <= (csr_wmask[CRMD_PLV_LSB +: CRMD_PLV_W] & csr_wvalue[CRMD_PLV_LSB +: CRMD_PLV_W])
                  | (~csr_wmask[CRMD_PLV_LSB +: CRMD_PLV_W] & crmd_plv);
        crmd_ie  <= csr_wmask[CRMD_IE] ? csr_wvalue[CRMD_IE] : crmd_ie;
      end

      if (wb_ex) begin
        prmd_pplv <= crmd_plv;
        prmd_pie  <= crmd_ie;
      end else if (wr_prmd) begin
        prmd_pplv <= (csr_wmask[PRMD_PPLV_LSB +: PRMD_PPLV_W] & csr_wvalue[PRMD_PPLV_LSB +: PRMD_PPLV_W])
                   | (~csr_wmask[PRMD_PPLV_LSB +: PRMD_PPLV_W] & prmd_pplv);
        prmd_pie  <= csr_wmask[PRMD_PIE] ? csr_wvalue[PRMD_PIE] : prmd_pie;
      end

      if (wr_ecfg) begin
        ecfg_lie <= ((csr_wmask[ECFG_LIE_W-1:0] & csr_wvalue[ECFG_LIE_W-1:0])
                   | (~csr_wmask[ECFG_LIE_W-1:0] & ecfg_lie)) & ECFG_LIE_MASK;
      end

      if (wr_estat) begin
        estat_is_sw <= (csr_wmask[ESTAT_IS_SW_W-1:0] & csr_wvalue[ESTAT_IS_SW_W-1:0])
                     | (~csr_wmask[ESTAT_IS_SW_W-1:0] & estat_is_sw);
      end

      if (wb_ex) begin
        estat_ecode    <= wb_ecode;
        estat_esubcode <= wb_esubcode;
        era            <= wb_pc;
      end else if (wr_era) begin
        era <= wmerge(era, csr_wmask, csr_wvalue);
      end

      if (wb_ex) begin
        if (wb_ecode == ECODE_ADEF)     badv <= wb_pc;
        else if (wb_ecode == ECODE_ALE) badv <= wb_vaddr;
      end else if (wr_badv) begin
        badv <= wmerge(badv, csr_wmask, csr_wvalue);
      end

      if (wr_eentry) begin
        eentry_va <= (csr_wmask[EENTRY_VA_LSB +: EENTRY_VA_W] & csr_wvalue[EENTRY_VA_LSB +: EENTRY_VA_W])
                   | (~csr_wmask[EENTRY_VA_LSB +: EENTRY_VA_W] & eentry_va);
      end

      if (wr_tid) tid <= wmerge(tid, csr_wmask, csr_wvalue);

      for (int i = 0; i < SAVE_NUM; i++) begin
        if (wr_save && (save_idx == i[3:0])) save_r[i] <= wmerge(save_r[i], csr_wmask, csr_wvalue);
      end
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit (SAVE_NUM=2); timer scenarios follow CSR_TIMER_EN.
module tb_csr_unit;

  localparam logic [31:0] TID_RST  = 32'h1234_5678;
  localparam logic [13:0] A_CRMD   = 14'h000;
  localparam logic [13:0] A_PRMD   = 14'h001;
  localparam logic [13:0] A_ECFG   = 14'h004;
  localparam logic [13:0] A_ESTAT  = 14'h005;
  localparam logic [13:0] A_ERA    = 14'h006;
  localparam logic [13:0] A_BADV   = 14'h007;
  localparam logic [13:0] A_EENTRY = 14'h00c;
  localparam logic [13:0] A_SAVE0  = 14'h030;
  localparam logic [13:0] A_SAVE1  = 14'h031;
  localparam logic [13:0] A_SAVE3  = 14'h033;
  localparam logic [13:0] A_TID    = 14'h040;
  localparam logic [13:0] A_TCFG   = 14'h041;
  localparam logic [13:0] A_TVAL   = 14'h042;
  localparam logic [13:0] A_TICLR  = 14'h044;
  localparam logic [5:0]  E_ADEF   = 6'h08;
  localparam logic [5:0]  E_ALE    = 6'h09;
  localparam logic [5:0]  E_SYS    = 6'h0b;
  localparam logic [31:0] ALL      = 32'hffff_ffff;

  logic        clk = 1'b0;
  logic        resetn;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;
  logic        has_int;

  int checks = 0;
  int errors = 0;

  csr_unit #(
    .SAVE_NUM   (2),
    .HW_INT_NUM (8),
    .TIMER_W    (32),
    .TID_RESET  (TID_RST)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .csr_re      (csr_re),
    .csr_num     (csr_num),
    .csr_rvalue  (csr_rvalue),
    .csr_we      (csr_we),
    .csr_wmask   (csr_wmask),
    .csr_wvalue  (csr_wvalue),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .ertn_flush  (ertn_flush),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .ex_entry    (ex_entry),
    .ertn_entry  (ertn_entry),
    .has_int     (has_int)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [13:0] num, output logic [31:0] v);
    csr_num = num;
    csr_re  = 1'b1;
    #1;
    v      = csr_rvalue;
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [13:0] num, input logic [31:0] m, input logic [31:0] d);
    csr_num    = num;
    csr_we     = 1'b1;
    csr_wmask  = m;
    csr_wvalue = d;
    tick(1);
    csr_we     = 1'b0;
    csr_wmask  = '0;
    csr_wvalue = '0;
  endtask

  task automatic ex(input logic [5:0] code, input logic [8:0] sub, input logic [31:0] pc,
                    input logic [31:0] va, input logic with_ertn);
    wb_ex       = 1'b1;
    wb_ecode    = code;
    wb_esubcode = sub;
    wb_pc       = pc;
    wb_vaddr    = va;
    ertn_flush  = with_ertn;
    tick(1);
    wb_ex      = 1'b0;
    ertn_flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn = 1'b1;
    csr_re = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wmask = '0; csr_wvalue = '0;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    ertn_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    #2 resetn = 1'b0;
    #13;
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL rst_has_int: got %b expected 0", has_int); end
    checks++; if (ex_entry !== 32'h0) begin errors++; $display("[TB] FAIL rst_ex_entry: got %h expected 0", ex_entry); end
    rd(A_TID, v);
    checks++; if (v !== TID_RST) begin errors++; $display("[TB] FAIL rst_tid: got %h expected %h", v, TID_RST); end
    #10 resetn = 1'b1;
    tick(1);
    rd(A_CRMD, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL rst_crmd: got %h expected 8", v); end
    rd(A_PRMD, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rst_prmd: got %h expected 0", v); end
    rd(A_ESTAT, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL rst_estat: got %h expected 0", v); end
    checks++; if (ertn_entry !== 32'h0) begin errors++; $display("[TB] FAIL rst_era: got %h expected 0", ertn_entry); end
  endtask

  task automatic test_exception();
    logic [31:0] v;
    wr(A_CRMD, 32'h7, 32'h7);
    rd(A_CRMD, v);
    checks++; if (v !== 32'hf) begin errors++; $display("[TB] FAIL crmd_write: got %h expected f", v); end
    ex(E_ALE, 9'h0, 32'h1c00_0100, 32'h0000_1003, 1'b0);
    rd(A_PRMD, v);
    checks++; if (v !== 32'h7) begin errors++; $display("[TB] FAIL ale_prmd: got %h expected 7", v); end
    rd(A_CRMD, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL ale_crmd: got %h expected 8", v); end
    rd(A_BADV, v);
    checks++; if (v !== 32'h1003) begin errors++; $display("[TB] FAIL ale_badv: got %h expected 1003", v); end
    rd(A_ERA, v);
    checks++; if (v !== 32'h1c00_0100) begin errors++; $display("[TB] FAIL ale_era: got %h expected 1c000100", v); end
    checks++; if (ertn_entry !== 32'h1c00_0100) begin errors++; $display("[TB] FAIL ale_ertn_entry: got %h expected 1c000100", ertn_entry); end
    rd(A_ESTAT, v);
    checks++; if (v !== 32'h0009_0000) begin errors++; $display("[TB] FAIL ale_estat: got %h expected 00090000", v); end
    ertn_flush = 1'b1;
    tick(1);
    ertn_flush = 1'b0;
    rd(A_CRMD, v);
    checks++; if (v !== 32'hf) begin errors++; $display("[TB] FAIL ertn_crmd: got %h expected f", v); end
    ex(E_ADEF, 9'h0, 32'h0000_2000, 32'h0000_5555, 1'b0);
    rd(A_BADV, v);
    checks++; if (v !== 32'h2000) begin errors++; $display("[TB] FAIL adef_badv: got %h expected 2000", v); end
    ex(E_SYS, 9'h1, 32'h0000_3000, 32'h0000_7777, 1'b0);
    rd(A_BADV, v);
    checks++; if (v !== 32'h2000) begin errors++; $display("[TB] FAIL sys_badv: got %h expected 2000", v); end
    rd(A_ESTAT, v);
    checks++; if (v !== 32'h004b_0000) begin errors++; $display("[TB] FAIL sys_estat: got %h expected 004b0000", v); end
    rd(A_PRMD, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL sys_prmd: got %h expected 0", v); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    wr(A_ERA, 32'hffff_0000, 32'habcd_1234);
    rd(A_ERA, v);
    checks++; if (v !== 32'habcd_3000) begin errors++; $display("[TB] FAIL era_mask: got %h expected abcd3000", v); end
    wr(A_EENTRY, ALL, ALL);
    rd(A_EENTRY, v);
    checks++; if (v !== 32'hffff_ffc0) begin errors++; $display("[TB] FAIL eentry: got %h expected ffffffc0", v); end
    checks++; if (ex_entry !== 32'hffff_ffc0) begin errors++; $display("[TB] FAIL ex_entry: got %h expected ffffffc0", ex_entry); end
    wr(A_ECFG, ALL, ALL);
    rd(A_ECFG, v);
    checks++; if (v !== 32'h1bff) begin errors++; $display("[TB] FAIL ecfg_lie: got %h expected 1bff", v); end
    wr(A_CRMD, ALL, 32'hffff_fff7);
    rd(A_CRMD, v);
    checks++; if (v !== 32'hf) begin errors++; $display("[TB] FAIL crmd_ro_bits: got %h expected f", v); end
    wr(14'h099, ALL, 32'h1234);
    rd(14'h099, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL unknown_csr: got %h expected 0", v); end
    csr_num = A_ERA;
    csr_re  = 1'b0;
    #1;
    checks++; if (csr_rvalue !== 32'h0) begin errors++; $display("[TB] FAIL re_low: got %h expected 0", csr_rvalue); end
  endtask

  task automatic test_save();
    logic [31:0] v;
    wr(A_SAVE3, ALL, 32'hdead);
    rd(A_SAVE3, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL save3_absent: got %h expected 0", v); end
    wr(A_SAVE1, ALL, 32'hbeef);
    rd(A_SAVE1, v);
    checks++; if (v !== 32'hbeef) begin errors++; $display("[TB] FAIL save1: got %h expected beef", v); end
    rd(A_SAVE0, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL save0: got %h expected 0", v); end
    wr(A_SAVE1, 32'h0000_ff00, 32'h0000_1200);
    rd(A_SAVE1, v);
    checks++; if (v !== 32'h12ef) begin errors++; $display("[TB] FAIL save1_mask: got %h expected 12ef", v); end
  endtask

  task automatic test_ex_ertn_same();
    logic [31:0] v;
    wr(A_PRMD, ALL, 32'h5);
    rd(A_PRMD, v);
    checks++; if (v !== 32'h5) begin errors++; $display("[TB] FAIL prmd_write: got %h expected 5", v); end
    ex(E_SYS, 9'h0, 32'h0000_4000, 32'h0, 1'b1);
    rd(A_CRMD, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL exertn_crmd: got %h expected 8", v); end
    rd(A_PRMD, v);
    checks++; if (v !== 32'h7) begin errors++; $display("[TB] FAIL exertn_prmd: got %h expected 7", v); end
    rd(A_ERA, v);
    checks++; if (v !== 32'h4000) begin errors++; $display("[TB] FAIL exertn_era: got %h expected 4000", v); end
  endtask

  task automatic test_interrupts();
    logic [31:0] v;
    hw_int_in  = 8'h05;
    ipi_int_in = 1'b1;
    rd(A_ESTAT, v);
    checks++; if ((v & 32'h1fff) !== 32'h0) begin errors++; $display("[TB] FAIL is_latency: got %h expected 0", v & 32'h1fff); end
    tick(1);
    rd(A_ESTAT, v);
    checks++; if ((v & 32'h1fff) !== 32'h1014) begin errors++; $display("[TB] FAIL is_sampled: got %h expected 1014", v & 32'h1fff); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL int_ie_off: got %b expected 0", has_int); end
    wr(A_ESTAT, ALL, ALL);
    rd(A_ESTAT, v);
    checks++; if ((v & 32'h1fff) !== 32'h1017) begin errors++; $display("[TB] FAIL is_sw: got %h expected 1017", v & 32'h1fff); end
    wr(A_CRMD, 32'h4, 32'h4);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL int_on: got %b expected 1", has_int); end
    wr(A_ECFG, ALL, 32'h400);
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL int_lie10: got %b expected 0", has_int); end
    wr(A_ECFG, ALL, 32'h1000);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL int_ipi: got %b expected 1", has_int); end
    ipi_int_in = 1'b0;
    tick(1);
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL int_ipi_drop: got %b expected 0", has_int); end
    hw_int_in = '0;
    wr(A_ESTAT, 32'h3, 32'h0);
    wr(A_ECFG, ALL, 32'h0);
    wr(A_CRMD, 32'h4, 32'h0);
  endtask

`ifdef CSR_TIMER_EN
  task automatic test_timer_oneshot();
    logic [31:0] v;
    wr(A_TCFG, ALL, 32'h11);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd16) begin errors++; $display("[TB] FAIL os_load: got %0d expected 16", v); end
    rd(A_TCFG, v);
    checks++; if (v !== 32'h11) begin errors++; $display("[TB] FAIL os_tcfg: got %h expected 11", v); end
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      rd(A_TVAL, v);
      checks++; if (v !== 32'(16 - k)) begin errors++; $display("[TB] FAIL os_count: cycle %0d got %0d expected %0d", k, v, 16 - k); end
      rd(A_ESTAT, v);
      checks++; if (v[11] !== (k == 16)) begin errors++; $display("[TB] FAIL os_ti: cycle %0d got %b expected %b", k, v[11], k == 16); end
    end
    tick(3);
    rd(A_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL os_hold: got %0d expected 0", v); end
    wr(A_TICLR, ALL, 32'h1);
    rd(A_ESTAT, v);
    checks++; if (v[11] !== 1'b0) begin errors++; $display("[TB] FAIL os_clear: got %b expected 0", v[11]); end
    rd(A_TICLR, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL ticlr_read: got %h expected 0", v); end
    wr(A_TCFG, ALL, 32'h0);
  endtask

  task automatic test_timer_periodic();
    logic [31:0] v;
    wr(A_TCFG, ALL, 32'h13);
    tick(16);
    rd(A_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL per_zero: got %0d expected 0", v); end
    rd(A_ESTAT, v);
    checks++; if (v[11] !== 1'b1) begin errors++; $display("[TB] FAIL per_ti1: got %b expected 1", v[11]); end
    tick(1);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd16) begin errors++; $display("[TB] FAIL per_reload: got %0d expected 16", v); end
    wr(A_TICLR, ALL, 32'h1);
    rd(A_ESTAT, v);
    checks++; if (v[11] !== 1'b0) begin errors++; $display("[TB] FAIL per_clear: got %b expected 0", v[11]); end
    rd(A_TVAL, v);
    checks++; if (v !== 32'd15) begin errors++; $display("[TB] FAIL per_run: got %0d expected 15", v); end
    tick(14);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd1) begin errors++; $display("[TB] FAIL per_one: got %0d expected 1", v); end
    wr(A_TICLR, ALL, 32'h1);
    rd(A_ESTAT, v);
    checks++; if (v[11] !== 1'b1) begin errors++; $display("[TB] FAIL per_set_wins: got %b expected 1", v[11]); end
    tick(1);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd16) begin errors++; $display("[TB] FAIL per_reload2: got %0d expected 16", v); end
    wr(A_TCFG, ALL, 32'h0);
    wr(A_TICLR, ALL, 32'h1);
  endtask

  task automatic test_timer_int();
    logic [31:0] v;
    wr(A_ECFG, ALL, 32'h800);
    wr(A_CRMD, 32'h4, 32'h4);
    wr(A_TCFG, ALL, 32'h5);
    tick(3);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd1) begin errors++; $display("[TB] FAIL ti_pre: got %0d expected 1", v); end
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL ti_int_early: got %b expected 0", has_int); end
    tick(1);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL ti_int_fire: got %b expected 1", has_int); end
    wr(A_TICLR, ALL, 32'h1);
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL ti_int_clear: got %b expected 0", has_int); end
    wr(A_TCFG, ALL, 32'h0);
    wr(A_CRMD, 32'h4, 32'h0);
    wr(A_ECFG, ALL, 32'h0);
  endtask
`else
  task automatic test_timer_disabled();
    logic [31:0] v;
    wr(A_TCFG, ALL, 32'h11);
    rd(A_TCFG, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_tcfg: got %h expected 0", v); end
    rd(A_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_tval: got %h expected 0", v); end
    tick(20);
    rd(A_ESTAT, v);
    checks++; if (v[11] !== 1'b0) begin errors++; $display("[TB] FAIL notimer_ti: got %b expected 0", v[11]); end
    wr(A_TICLR, ALL, 32'h1);
    rd(A_TICLR, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL notimer_ticlr: got %h expected 0", v); end
  endtask
`endif

  task automatic test_async_reset();
    logic [31:0] v;
    wr(A_TID, ALL, 32'hcafe_f00d);
    rd(A_TID, v);
    checks++; if (v !== 32'hcafe_f00d) begin errors++; $display("[TB] FAIL tid_write: got %h expected cafef00d", v); end
    wr(A_ESTAT, 32'h3, 32'h3);
    wr(A_ECFG, ALL, 32'h3);
    wr(A_CRMD, 32'h4, 32'h4);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL ar_int_pre: got %b expected 1", has_int); end
`ifdef CSR_TIMER_EN
    wr(A_TCFG, ALL, 32'h11);
    tick(5);
    rd(A_TVAL, v);
    checks++; if (v !== 32'd11) begin errors++; $display("[TB] FAIL ar_tval_pre: got %0d expected 11", v); end
`endif
    #4 resetn = 1'b0;
    #1;
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL ar_has_int: got %b expected 0", has_int); end
    checks++; if (ex_entry !== 32'h0) begin errors++; $display("[TB] FAIL ar_ex_entry: got %h expected 0", ex_entry); end
    rd(A_TID, v);
    checks++; if (v !== TID_RST) begin errors++; $display("[TB] FAIL ar_tid: got %h expected %h", v, TID_RST); end
    rd(A_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL ar_tval: got %0d expected 0", v); end
    rd(A_CRMD, v);
    checks++; if (v !== 32'h8) begin errors++; $display("[TB] FAIL ar_crmd: got %h expected 8", v); end
    #3 resetn = 1'b1;
    tick(2);
    rd(A_TVAL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL ar_tval_post: got %0d expected 0", v); end
  endtask

  initial begin
    test_reset();
    test_exception();
    test_regs();
    test_save();
    test_ex_ertn_same();
    test_interrupts();
`ifdef CSR_TIMER_EN
    test_timer_oneshot();
    test_timer_periodic();
    test_timer_int();
`else
    test_timer_disabled();
`endif
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
